sr_cmd_gen: RTL and testbench

Upstream command generator for the SR flip-flop stage. Takes two raw, noisy, asynchronous request lines (set, clear) and produces clean, debounced, single-source S/R pulses. It guarantees S and R are never asserted together, so the downstream flip-flop never enters its invalid state. Conflicting requests are resolved by a fixed priority rule and flagged.

---
 rtl/sr_ctrl_pkg.sv | 22 ++
 rtl/sr_cmd_gen_if.sv | 35 +++
 rtl/sr_debounce.sv | 57 +++++
 rtl/sr_cmd_gen.sv | 137 +++++++++++++
 tb/tb_sr_cmd_gen.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR command generator: FSM state encoding,
// priority encoding and the counter-width helper.
// No ports (package).
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } sr_state_e;

    // Values accepted by the CLR_PRIORITY parameter.
    localparam int unsigned PRIO_SET = 0;
    localparam int unsigned PRIO_CLR = 1;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sr_cmd_gen_if.sv
// Request/command bundle between the request source and sr_cmd_gen.
// Signals:
//   set_in, clr_in : raw, asynchronous, possibly bouncing requests
//   S, R           : registered set/reset pulses to the flip-flop stage
//   busy           : generator is not idle
//   conflict       : sticky flag, a request was dropped by priority
// Modports: master = request source / pulse consumer, slave = generator.
interface sr_cmd_gen_if;

    logic set_in;
    logic clr_in;
    logic S;
    logic R;
    logic busy;
    logic conflict;

    modport master (
        output set_in,
        output clr_in,
        input  S,
        input  R,
        input  busy,
        input  conflict
    );

    modport slave (
        input  set_in,
        input  clr_in,
        output S,
        output R,
        output busy,
        output conflict
    );

endinterface

// File: rtl/sr_debounce.sv
// One request channel: 2-flop synchronizer, counter debouncer and
// rising-edge detector producing a one-cycle request.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   din  : raw asynchronous input
//   req  : one-cycle pulse on each debounced rising edge of din
module sr_debounce
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic req
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync0;
    logic          sync1;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    // Synchronize, then accept a new level only after it has held for
    // DEBOUNCE_CYCLES consecutive edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0    <= 1'b0;
            sync1    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync0    <= din;
            sync1    <= sync0;
            stable_d <= stable;
            if (sync1 != stable) begin
                if (cnt == CNT_MAX) begin
                    stable <= sync1;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Built from flops only; falling edges produce nothing.
    assign req = stable & ~stable_d;

endmodule

// File: rtl/sr_cmd_gen.sv
// Command generator for the SR flip-flop stage: turns two noisy request
// lines into clean, mutually exclusive S/R pulses with an enforced idle gap.
// Simultaneous requests are resolved by CLR_PRIORITY and flagged.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : sr_cmd_gen_if slave (set_in, clr_in in; S, R, busy, conflict out)
module sr_cmd_gen
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_CYCLES    = 1,
    parameter int unsigned GAP_CYCLES      = 1,
    parameter int unsigned CLR_PRIORITY    = 1
) (
    input  logic          clk,
    input  logic          rst,
    sr_cmd_gen_if.slave   bus
);

    localparam int unsigned PW = cnt_width(PULSE_CYCLES);
    localparam int unsigned GW = cnt_width(GAP_CYCLES);
    localparam logic [PW-1:0] PULSE_MAX = PW'(PULSE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_CYCLES - 1);
    localparam logic          CLR_WINS  = (CLR_PRIORITY == PRIO_CLR);

    sr_state_e     state;
    logic          req_s;
    logic          req_r;
    logic          pend_s;
    logic          pend_r;
    logic [PW-1:0] pcnt;
    logic [GW-1:0] gcnt;
    logic          s_q;
    logic          r_q;
    logic          busy_q;
    logic          conflict_q;

    logic          decide;
    logic          eff_s;
    logic          eff_r;
    logic          both;
    logic          go_s;
    logic          go_r;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_s (
        .clk (clk),
        .rst (rst),
        .din (bus.set_in),
        .req (req_s)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
        .clk (clk),
        .rst (rst),
        .din (bus.clr_in),
        .req (req_r)
    );

    // Arbitration point: IDLE, or the last gap cycle so back-to-back pulses
    // start exactly PULSE_CYCLES+GAP_CYCLES apart.
    always_comb begin
        decide = (state == IDLE) || ((state == GAP) && (gcnt == GAP_MAX));
        eff_s  = req_s | pend_s;
        eff_r  = req_r | pend_r;
        both   = eff_s & eff_r;
        go_s   = eff_s & ~(eff_r & CLR_WINS);
        go_r   = eff_r & ~(eff_s & ~CLR_WINS);
    end

    // FSM, pending bits, pulse/gap counters and sticky conflict flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend_s     <= 1'b0;
            pend_r     <= 1'b0;
            pcnt       <= '0;
            gcnt       <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else if (decide) begin
            // Every live request is consumed here: served or dropped.
            pend_s <= 1'b0;
            pend_r <= 1'b0;
            if (both) begin
                conflict_q <= 1'b1;
            end
            if (go_s) begin
                state  <= PULSE_S;
                s_q    <= 1'b1;
                busy_q <= 1'b1;
                pcnt   <= '0;
            end else if (go_r) begin
                state  <= PULSE_R;
                r_q    <= 1'b1;
                busy_q <= 1'b1;
                pcnt   <= '0;
            end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end
        end else begin
            // Repeats while busy merge into a single pending request.
            if (req_s) begin
                pend_s <= 1'b1;
            end
            if (req_r) begin
                pend_r <= 1'b1;
            end
            case (state)
                PULSE_S, PULSE_R: begin
                    if (pcnt == PULSE_MAX) begin
                        state <= GAP;
                        s_q   <= 1'b0;
                        r_q   <= 1'b0;
                        gcnt  <= '0;
                    end else begin
                        pcnt <= pcnt + PW'(1);
                    end
                end
                GAP: begin
                    gcnt <= gcnt + GW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.S        = s_q;
    assign bus.R        = r_q;
    assign bus.busy     = busy_q;
    assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen. Three instances share stimulus:
//   a: defaults (clear wins), b: set wins, c: PULSE_CYCLES=3, GAP_CYCLES=2.
module tb_sr_cmd_gen;

    logic clk;
    logic rst;
    logic set_in;
    logic clr_in;

    sr_cmd_gen_if ifa();
    sr_cmd_gen_if ifb();
    sr_cmd_gen_if ifc();

    assign ifa.set_in = set_in;
    assign ifa.clr_in = clr_in;
    assign ifb.set_in = set_in;
    assign ifb.clr_in = clr_in;
    assign ifc.set_in = set_in;
    assign ifc.clr_in = clr_in;

    sr_cmd_gen u_a (.clk(clk), .rst(rst), .bus(ifa));

    sr_cmd_gen #(.CLR_PRIORITY(0)) u_b (.clk(clk), .rst(rst), .bus(ifb));

    sr_cmd_gen #(.PULSE_CYCLES(3), .GAP_CYCLES(2)) u_c (.clk(clk), .rst(rst), .bus(ifc));

    logic [2:0] so;
    logic [2:0] ro;
    logic [2:0] bo;
    logic [2:0] co;
    assign so = {ifc.S, ifb.S, ifa.S};
    assign ro = {ifc.R, ifb.R, ifa.R};
    assign bo = {ifc.busy, ifb.busy, ifa.busy};
    assign co = {ifc.conflict, ifb.conflict, ifa.conflict};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output nibble is {S, R, busy, conflict}.
    localparam logic [3:0] E_0  = 4'b0000;
    localparam logic [3:0] E_SB = 4'b1010;
    localparam logic [3:0] E_RB = 4'b0110;
    localparam logic [3:0] E_B  = 4'b0010;

    typedef struct {
        int         reps;
        logic       rst;
        logic       set;
        logic       clr;
        int         inst;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp;
    int   n_err;
    int   s_hi[3];
    int   r_hi[3];
    logic overlap;

    function automatic void add(input int reps, input logic r, input logic s,
                                input logic c, input int inst, input logic [3:0] e);
        vec_t v;
        v.reps = reps;
        v.rst  = r;
        v.set  = s;
        v.clr  = c;
        v.inst = inst;
        v.exp  = e;
        tbl.push_back(v);
    endfunction

    // One clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            if (so[j] === 1'b1 && ro[j] === 1'b1) overlap = 1'b1;
            if (so[j] === 1'b1) s_hi[j]++;
            if (ro[j] === 1'b1) r_hi[j]++;
        end
    endtask

    task automatic clear_counts();
        for (int j = 0; j < 3; j++) begin
            s_hi[j] = 0;
            r_hi[j] = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        set_in = 1'b0;
        clr_in = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        overlap = 1'b0;
        rst     = 1'b1;
        set_in  = 1'b0;
        clr_in  = 1'b0;
        clear_counts();

        // Clean set press on a: S after edge t0+6 for one cycle, one gap cycle.
        add(2,  1, 0, 0, 0, E_0);
        add(6,  0, 1, 0, 0, E_0);
        add(1,  0, 1, 0, 0, E_SB);
        add(1,  0, 1, 0, 0, E_B);
        add(5,  0, 1, 0, 0, E_0);
        add(10, 0, 0, 0, 0, E_0);
        // set_in held high through reset release on a: one pulse only.
        add(2,  1, 1, 0, 0, E_0);
        add(6,  0, 1, 0, 0, E_0);
        add(1,  0, 1, 0, 0, E_SB);
        add(1,  0, 1, 0, 0, E_B);
        add(12, 0, 1, 0, 0, E_0);
        add(8,  0, 0, 0, 0, E_0);
        // Clear debounces during a 3-cycle S pulse on c: 2 gap cycles then R.
        add(2,  1, 0, 0, 2, E_0);
        add(1,  0, 1, 0, 2, E_0);
        add(5,  0, 1, 1, 2, E_0);
        add(3,  0, 1, 1, 2, E_SB);
        add(2,  0, 1, 1, 2, E_B);
        add(3,  0, 1, 1, 2, E_RB);
        add(2,  0, 1, 1, 2, E_B);
        add(6,  0, 1, 1, 2, E_0);
        add(10, 0, 0, 0, 2, E_0);
        // Reset in the 2nd S cycle on c with a clear pending: nothing survives.
        add(2,  1, 0, 0, 2, E_0);
        add(1,  0, 1, 0, 2, E_0);
        add(5,  0, 1, 1, 2, E_0);
        add(2,  0, 1, 1, 2, E_SB);
        add(1,  1, 0, 0, 2, E_0);
        add(15, 0, 0, 0, 2, E_0);

        foreach (tbl[i]) begin
            rst    = tbl[i].rst;
            set_in = tbl[i].set;
            clr_in = tbl[i].clr;
            for (int k = 0; k < tbl[i].reps; k++) begin
                logic [3:0] act;
                step();
                act = {so[tbl[i].inst], ro[tbl[i].inst], bo[tbl[i].inst], co[tbl[i].inst]};
                n_cmp++;
                if (act !== tbl[i].exp) begin
                    n_err++;
                    $display("FAIL vec row%0d cyc%0d inst%0d: got %b want %b (S,R,busy,conflict)",
                             i, k, tbl[i].inst, act, tbl[i].exp);
                end
            end
        end

        // Bouncy clear on a: 3-cycle glitch ignored, stable level gives one R.
        do_reset();
        clear_counts();
        clr_in = 1'b1;
        repeat (3) step();
        clr_in = 1'b0;
        repeat (8) step();
        check("glitch_no_r", r_hi[0], 0);
        check("glitch_no_s", s_hi[0], 0);
        check("glitch_busy", int'(bo[0]), 0);
        clr_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("bounce_r_cyc%0d", k), int'(ro[0]), (k == 6) ? 1 : 0);
        end
        clr_in = 1'b0;
        repeat (10) step();
        check("bounce_one_r", r_hi[0], 1);
        check("bounce_no_s", s_hi[0], 0);
        check("bounce_no_conflict", int'(co[0]), 0);

        // Simultaneous presses: a (clear wins) vs b (set wins), both flag.
        do_reset();
        clear_counts();
        set_in = 1'b1;
        clr_in = 1'b1;
        repeat (12) step();
        set_in = 1'b0;
        clr_in = 1'b0;
        repeat (10) step();
        check("sim_a_s_cycles", s_hi[0], 0);
        check("sim_a_r_cycles", r_hi[0], 1);
        check("sim_a_conflict", int'(co[0]), 1);
        check("sim_b_s_cycles", s_hi[1], 1);
        check("sim_b_r_cycles", r_hi[1], 0);
        check("sim_b_conflict", int'(co[1]), 1);
        check("sim_c_r_cycles", r_hi[2], 3);
        check("sim_c_s_cycles", s_hi[2], 0);
        repeat (10) step();
        check("sticky_a_conflict", int'(co[0]), 1);
        check("sticky_b_conflict", int'(co[1]), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_a_conflict", int'(co[0]), 0);
        check("rst_b_conflict", int'(co[1]), 0);
        check("rst_a_busy", int'(bo[0]), 0);

        check("s_and_r_never_both", int'(overlap), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
